seg7_capture: RTL and testbench

SEG7_CAPTURE -- requirements
Module: seg7_capture

---
 rtl/seg7_capture_if.sv | 23 ++
 rtl/seg7_capture.sv | 126 ++++++++++++
 tb/tb_seg7_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// rtl/seg7_capture_if.sv - sampled 7-segment display lines and captured digit results
interface seg7_capture_if #(
    parameter int DIGITS = 4
);
    logic                  sample_en;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     dig_sel;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     digit_valid;
    logic [4*DIGITS-1:0]   frame_value;
    logic                  frame_valid;
    logic                  err;

    modport master (
        output sample_en, seg_n, dig_sel,
        input  value, digit_valid, frame_value, frame_valid, err
    );

    modport slave (
        input  sample_en, seg_n, dig_sel,
        output value, digit_valid, frame_value, frame_valid, err
    );
endinterface

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - debounced capture of a multiplexed 7-segment display into hex nibbles
module seg7_capture #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic            clk,
    input  logic            rst,
    seg7_capture_if.slave   bus
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_CNT);
    localparam logic [DIGITS-1:0] TOP_BIT = DIGITS'(1) << (DIGITS - 1);

    logic [DIGITS-1:0]   prev_sel;
    logic [6:0]          prev_seg;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   digit_valid_q;
    logic [4*DIGITS-1:0] frame_value_q;
    logic                frame_valid_q;
    logic                err_q;

    logic                onehot;
    logic                match;
    logic [CW-1:0]       cnt_next;
    logic                capture;
    logic                dec_ok;
    logic [3:0]          dec_nib;
    logic [4*DIGITS-1:0] value_next;
    logic [DIGITS-1:0]   dv_next;
    logic                frame_hit;

    // Segment lines are active-low, bit 6..0 = g..a; returns {valid, nibble}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0011000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Stability tracking, capture detection and next digit/frame contents
    always_comb begin
        onehot   = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - DIGITS'(1))) == '0);
        match    = (cnt != '0) && (bus.dig_sel == prev_sel) && (bus.seg_n == prev_seg);
        cnt_next = CW'(1);
        if (!onehot) begin
            cnt_next = '0;
        end else if (match) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        end
        // A counter already parked at the threshold must not fire again
        capture = onehot && (cnt_next == CNT_MAX) && !(match && (cnt == CNT_MAX));
        {dec_ok, dec_nib} = decode(bus.seg_n);
        value_next = value_q;
        dv_next    = digit_valid_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.dig_sel[i]) begin
                if (dec_ok) begin
                    value_next[4*i +: 4] = dec_nib;
                end
                dv_next[i] = dec_ok;
            end
        end
        // Frame completes when the last digit lands with all lower digits already valid
        frame_hit = capture && dec_ok && bus.dig_sel[DIGITS-1] &&
                    ((digit_valid_q | TOP_BIT) == '1);
    end

    // Registered state; pulses clear on every edge and only sample_en edges advance state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sel      <= '0;
            prev_seg      <= 7'h7F;
            cnt           <= '0;
            value_q       <= '0;
            digit_valid_q <= '0;
            frame_value_q <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            if (bus.sample_en) begin
                if (onehot) begin
                    prev_sel <= bus.dig_sel;
                    prev_seg <= bus.seg_n;
                end
                cnt <= cnt_next;
                if (capture) begin
                    value_q <= value_next;
                    if (!dec_ok) begin
                        err_q <= 1'b1;
                    end
                    if (frame_hit) begin
                        frame_value_q <= value_next;
                        frame_valid_q <= 1'b1;
                        digit_valid_q <= '0;
                    end else begin
                        digit_valid_q <= dv_next;
                    end
                end
            end
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.frame_value = frame_value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed checks of seg7_capture with DIGITS=4, STABLE_CNT=3
module tb_seg7_capture;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SX = 7'b1111111;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   frames;
    int   errs;

    seg7_capture_if #(.DIGITS(4)) bus ();

    seg7_capture #(.DIGITS(4), .STABLE_CNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] sel, input logic [6:0] seg);
        bus.sample_en = 1'b1;
        bus.dig_sel   = sel;
        bus.seg_n     = seg;
        @(posedge clk);
        #1;
        bus.sample_en = 1'b0;
    endtask

    task automatic idle();
        bus.sample_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input logic [3:0] sel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) tick(sel, seg);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.sample_en = 1'b0;
        bus.dig_sel = 4'b0000;
        bus.seg_n = SX;
        #1;
        check("reset_value", bus.value, 16'h0000);
        check("reset_dv", bus.digit_valid, 4'b0000);
        check("reset_frame", bus.frame_value, 16'h0000);
        check("reset_pulses", {bus.frame_valid, bus.err}, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two stable ticks do nothing, third captures '2' on digit 0
        ticks(4'b0001, S2, 2);
        check("pre_capture_value", bus.value, 16'h0000);
        check("pre_capture_dv", bus.digit_valid, 4'b0000);
        tick(4'b0001, S2);
        check("capture_value", bus.value, 16'h0002);
        check("capture_dv", bus.digit_valid, 4'b0001);
        check("capture_err", bus.err, 1'b0);

        // Full frame 4,3,2,1
        ticks(4'b0001, S1, 3);
        check("d0_recapture", bus.value, 16'h0001);
        ticks(4'b0010, S2, 3);
        ticks(4'b0100, S3, 3);
        check("three_digits_dv", bus.digit_valid, 4'b0111);
        ticks(4'b1000, S4, 2);
        check("frame_not_yet", bus.frame_valid, 1'b0);
        tick(4'b1000, S4);
        check("frame_pulse", bus.frame_valid, 1'b1);
        check("frame_value", bus.frame_value, 16'h4321);
        check("frame_dv_clear", bus.digit_valid, 4'b0000);
        idle();
        check("frame_pulse_end", bus.frame_valid, 1'b0);
        check("frame_value_hold", bus.frame_value, 16'h4321);

        // Invalid pattern on a valid digit 2, with a hold edge in the middle
        ticks(4'b0100, S7, 3);
        check("d2_seven", bus.value, 16'h4721);
        check("d2_seven_dv", bus.digit_valid, 4'b0100);
        ticks(4'b0100, SX, 2);
        idle();
        check("hold_no_err", bus.err, 1'b0);
        tick(4'b0100, SX);
        check("err_pulse", bus.err, 1'b1);
        check("err_dv", bus.digit_valid, 4'b0000);
        check("err_value_kept", bus.value, 16'h4721);
        idle();
        check("err_pulse_end", bus.err, 1'b0);

        // Glitch with two selects restarts stability
        ticks(4'b0010, S5, 2);
        tick(4'b0011, S5);
        tick(4'b0010, S5);
        check("glitch_no_early", bus.value, 16'h4721);
        tick(4'b0010, S5);
        check("glitch_no_early2", bus.value, 16'h4721);
        tick(4'b0010, S5);
        check("glitch_capture", bus.value, 16'h4751);
        check("glitch_dv", bus.digit_valid, 4'b0010);

        // Long holds capture once only
        ticks(4'b0001, S1, 3);
        ticks(4'b0100, S3, 3);
        check("long_pre_dv", bus.digit_valid, 4'b0111);
        frames = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b1000, SF);
            frames += int'(bus.frame_valid);
        end
        check("long_frames", frames, 1);
        check("long_frame_value", bus.frame_value, 16'hF351);
        check("long_dv", bus.digit_valid, 4'b0000);
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b0001, SX);
            errs += int'(bus.err);
        end
        check("long_errs", errs, 1);

        // Reset between edges discards partial progress
        ticks(4'b0001, S2, 3);
        check("pre_rst_value", bus.value, 16'hF352);
        ticks(4'b0010, S5, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_value", bus.value, 16'h0000);
        check("async_dv", bus.digit_valid, 4'b0000);
        check("async_frame", bus.frame_value, 16'h0000);
        #1;
        rst = 1'b0;
        ticks(4'b0010, S5, 2);
        check("post_rst_restart", bus.value, 16'h0000);
        tick(4'b0010, S5);
        check("post_rst_capture", bus.value, 16'h0050);
        ticks(4'b0100, S3, 3);
        ticks(4'b1000, S4, 3);
        check("no_frame_missing_d0", bus.frame_valid, 1'b0);
        check("partial_dv", bus.digit_valid, 4'b1110);
        check("partial_value", bus.value, 16'h4350);
        ticks(4'b0001, S1, 3);
        ticks(4'b1000, S4, 3);
        check("refill_frame", bus.frame_valid, 1'b1);
        check("refill_frame_value", bus.frame_value, 16'h4351);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
